keypad_scan_onehot: RTL and testbench

//  4x4 matrix keypad scanner with debounce. Drives rows, samples columns, emits a one-hot key vector.

---
 rtl/keypad_pkg.sv | 50 +++++
 rtl/keypad_col_sync.sv | 34 +++
 rtl/keypad_scan_onehot.sv | 177 +++++++++++++++++
 tb/tb_keypad_scan_onehot.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
//   Shared types, geometry and helpers for the 4x4 keypad scanner.
//
//   Contents:
//     ROWS / COLS / KEYS   keypad geometry (4 x 4 = 16 keys)
//     state_t              scanner FSM state encoding (2 bits)
//     key_index()          row/column -> key number (row*COLS + col)
//     lowest_col()         index of the lowest set bit of a column vector
//     row_drive()          active-low row drive pattern for a row index
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KEYS = ROWS * COLS;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Key number as seen by the downstream 16:4 encoder.
    function automatic logic [3:0] key_index(input logic [1:0] row,
                                             input logic [1:0] col);
        return 4'(int'(row) * COLS + int'(col));
    endfunction

    // Lowest pressed column wins when several columns of one row are low.
    function automatic logic [1:0] lowest_col(input logic [COLS-1:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (cols[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Exactly one row pulled low; all others released.
    function automatic logic [ROWS-1:0] row_drive(input logic [1:0] row);
        logic [ROWS-1:0] sel;
        sel = 4'b0001 << row;
        return ~sel;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// -----------------------------------------------------------------------------
// keypad_col_sync
//   Two-flop synchronizer for the asynchronous, active-low column inputs.
//   Resets to 4'b1111 so that "nothing pressed" is seen during and right
//   after reset.
//
//   Ports:
//     clk   in   1   system clock
//     rst   in   1   asynchronous, active-high reset
//     d     in   4   raw column levels (asynchronous to clk)
//     q     out  4   synchronized column levels (2 clk latency)
// -----------------------------------------------------------------------------
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] d,
    output logic [COLS-1:0] q
);

    logic [COLS-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_onehot.sv
// -----------------------------------------------------------------------------
// keypad_scan_onehot
//   4x4 matrix keypad scanner with debounce. Walks an active-low drive across
//   the rows, samples the synchronized columns at the end of each row dwell,
//   debounces a press, and presents it as a one-hot key vector with a
//   valid/ready handshake. key_onehot[15:0] feeds a 16:4 encoder directly, so
//   the encoder output equals the key number row*4+col.
//
//   Handshake: key_valid rises together with a single-bit key_onehot and both
//   stay constant until a cycle with key_valid && key_ready; on the following
//   clock both drop to zero. key_ready while key_valid is low has no effect.
//   key_onehot is all-zero whenever key_valid is low.
//
//   Parameters:
//     SCAN_DIV      clocks each row is driven before sampling (>= 4)
//     DEBOUNCE_CNT  consecutive stable clocks to accept a press/release (>= 2)
//
//   Ports:
//     clk         in   1   system clock
//     rst         in   1   asynchronous, active-high reset
//     col_n       in   4   column sense, active-low, asynchronous
//     row_n       out  4   row drive, active-low, one row low at a time
//     key_onehot  out  16  one-hot debounced key, bit row*4+col
//     key_valid   out  1   key_onehot holds a debounced press
//     key_ready   in   1   consumer accepts the held event
//     state_dbg   out  2   current FSM state (state_t encoding)
//
//   Build option KEYPAD_GHOST_REJECT_EN: when defined, a row sample with more
//   than one column pressed is discarded instead of resolved to the lowest
//   column, and debounce is abandoned if several columns become pressed.
// -----------------------------------------------------------------------------
module keypad_scan_onehot
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col_n,
    output logic [ROWS-1:0] row_n,
    output logic [KEYS-1:0] key_onehot,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [1:0]      state_dbg
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DBC_W  = $clog2(DEBOUNCE_CNT);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DBC_W-1:0]  DBC_LAST  = DBC_W'(DEBOUNCE_CNT - 1);

    // ------------------------------------------------------------------
    // Column synchronizer
    // ------------------------------------------------------------------
    logic [COLS-1:0] col_s;
    logic [COLS-1:0] pressed;

    keypad_col_sync u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (col_n),
        .q   (col_s)
    );

    assign pressed = ~col_s;

    // ------------------------------------------------------------------
    // Multi-column detection (only meaningful with ghost rejection)
    // ------------------------------------------------------------------
    logic multi_col;

`ifdef KEYPAD_GHOST_REJECT_EN
    assign multi_col = ($countones(pressed) > 1);
`else
    assign multi_col = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM, counters and output registers
    // ------------------------------------------------------------------
    state_t            state;
    logic [1:0]        row_idx;
    logic [1:0]        row_next;
    logic [SCAN_W-1:0] scan_cnt;
    logic [DBC_W-1:0]  dbc;
    logic [COLS-1:0]   col_lat;

    assign row_next  = row_idx + 2'd1;   // natural 3 -> 0 wrap
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SCAN;
            row_idx    <= 2'd0;
            row_n      <= 4'b1110;
            key_onehot <= '0;
            key_valid  <= 1'b0;
            scan_cnt   <= '0;
            dbc        <= '0;
            col_lat    <= '0;
        end else begin
            case (state)
                // Drive the current row for SCAN_DIV clocks. The sample is
                // taken on the last dwell cycle, by which point the
                // synchronizer reflects columns of this row only.
                SCAN: begin
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if ((pressed != '0) && !multi_col) begin
                            col_lat <= pressed;
                            dbc     <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            row_idx <= row_next;
                            row_n   <= row_drive(row_next);
                        end
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end

                // Row stays driven; the column pattern must hold unchanged
                // for DEBOUNCE_CNT clocks. Any change abandons the press and
                // scanning resumes on the next row.
                DEBOUNCE: begin
                    if ((pressed != col_lat) || multi_col) begin
                        state    <= SCAN;
                        scan_cnt <= '0;
                        dbc      <= '0;
                        row_idx  <= row_next;
                        row_n    <= row_drive(row_next);
                    end else if (dbc == DBC_LAST) begin
                        key_onehot <= KEYS'(1) << key_index(row_idx, lowest_col(col_lat));
                        key_valid  <= 1'b1;
                        state      <= PRESSED;
                    end else begin
                        dbc <= dbc + 1'b1;
                    end
                end

                // Event held, independent of the pad, until accepted.
                PRESSED: begin
                    if (key_ready) begin
                        key_valid  <= 1'b0;
                        key_onehot <= '0;
                        dbc        <= '0;
                        state      <= RELEASE;
                    end
                end

                // Wait for the accepted key's row to read released for
                // DEBOUNCE_CNT consecutive clocks; a held key never
                // re-triggers.
                RELEASE: begin
                    if (pressed != '0) begin
                        dbc <= '0;
                    end else if (dbc == DBC_LAST) begin
                        state    <= SCAN;
                        scan_cnt <= '0;
                        dbc      <= '0;
                        row_idx  <= row_next;
                        row_n    <= row_drive(row_next);
                    end else begin
                        dbc <= dbc + 1'b1;
                    end
                end

                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_onehot.sv
module tb_keypad_scan_onehot;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
    localparam int WAIT_BUDGET  = 200;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] key_onehot;
    logic        key_valid;
    logic        key_ready;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    keypad_scan_onehot #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .col_n      (col_n),
        .row_n      (row_n),
        .key_onehot (key_onehot),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .state_dbg  (state_dbg)
    );

    // Pad model: a held key pulls its column low only while its row is driven.
    logic [15:0] pad_keys;

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pad_keys[r*4+c] && !row_n[r]) begin
                    col_n[c] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int          checks    = 0;
    int          failures  = 0;
    int          transfers = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoder downstream of key_onehot: binary key number.
    function automatic logic [3:0] enc16(input logic [15:0] d);
        for (int i = 0; i < 16; i++) begin
            if (d[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Continuous invariants and handshake transfers, sampled on negedge.
    always @(negedge clk) begin
        if (!rst) begin
            check("one_row_low", $countones(~row_n), 1);
            check("onehot_at_most_one", ($countones(key_onehot) <= 1), 1);
            if (!key_valid) check("onehot_zero_when_idle", key_onehot, 0);
            if (key_valid && key_ready) begin
                transfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_transfer: got 0x%0h expected no event at %0t",
                             key_onehot, $time);
                end else begin
                    check("transfer_onehot", key_onehot, exp_q.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive_keys(input logic [15:0] k);
        @(posedge clk);
        #1 pad_keys = k;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_valid: got no key_valid expected one within %0d cycles", budget);
        end
    endtask

    typedef struct {
        logic [15:0] keys;
        logic [15:0] exp_onehot;
        logic [3:0]  exp_y;
    } vec_t;

    vec_t vecs[7];

    task automatic apply_vec(input vec_t v);
        bit ok;
        @(posedge clk);
        #1;
        key_ready = 1'b1;
        exp_q.push_back(v.exp_onehot);
        pad_keys = v.keys;
        wait_valid(WAIT_BUDGET, ok);
        if (ok) begin
            check("vec_onehot", key_onehot, v.exp_onehot);
            check("vec_encoder_y", enc16(key_onehot), v.exp_y);
            @(negedge clk);
            check("vec_valid_single_cycle", key_valid, 0);
        end
        drive_keys(16'h0000);
        repeat (40) @(posedge clk);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    logic [3:0] rows_exp[5];
    int         base;
    int         bad;
    bit         ok;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        key_ready = 1'b0;
        pad_keys  = 16'h0000;
        rows_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        vecs[0] = '{16'h0200, 16'h0200, 4'd9};
        vecs[1] = '{16'h0001, 16'h0001, 4'd0};
        vecs[2] = '{16'h8000, 16'h8000, 4'd15};
        vecs[3] = '{16'h0020, 16'h0020, 4'd5};
        vecs[4] = '{16'h0400, 16'h0400, 4'd10};
        vecs[5] = '{16'h1000, 16'h1000, 4'd12};
        vecs[6] = '{16'h0080, 16'h0080, 4'd7};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset pulse mid-scan: outputs return asynchronously.
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_row_n", row_n, 4'b1110);
        check("rst_async_valid", key_valid, 0);
        check("rst_async_onehot", key_onehot, 0);
        check("rst_async_state", state_dbg, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("row_cycle", row_n, rows_exp[i]);
            repeat (4) @(negedge clk);
        end

        // Reset while an event is held: event vanishes, nothing transfers.
        drive_keys(16'h0020);
        wait_valid(WAIT_BUDGET, ok);
        if (ok) check("held_before_rst", key_onehot, 16'h0020);
        #2 rst = 1'b1;
        #1;
        check("rst_event_valid", key_valid, 0);
        check("rst_event_onehot", key_onehot, 0);
        check("rst_event_row_n", row_n, 4'b1110);
        pad_keys = 16'h0000;
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        check("rst_no_event", transfers, 0);

        // Single-key presses across the matrix.
        for (int i = 0; i < 7; i++) begin
            apply_vec(vecs[i]);
        end
        check("table_events", transfers, 7);

        // Bounce on r0/c3, then stable.
        base = transfers;
        @(posedge clk);
        #1 key_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (t % 3 == 0) pad_keys[3] = ~pad_keys[3];
            @(posedge clk);
            #1;
        end
        check("bounce_no_event", transfers - base, 0);
        exp_q.push_back(16'h0008);
        pad_keys = 16'h0008;
        wait_valid(WAIT_BUDGET, ok);
        if (ok) check("bounce_onehot", key_onehot, 16'h0008);
        drive_keys(16'h0000);
        repeat (40) @(posedge clk);
        check("bounce_one_event", transfers - base, 1);

        // Backpressure on r3/c3, key released while the event is held.
        base = transfers;
        @(posedge clk);
        #1 key_ready = 1'b0;
        exp_q.push_back(16'h8000);
        pad_keys = 16'h8000;
        wait_valid(WAIT_BUDGET, ok);
        bad = 0;
        for (int t = 0; t < 50; t++) begin
            if (t == 10) pad_keys = 16'h0000;
            @(negedge clk);
            if (!key_valid || key_onehot !== 16'h8000) bad++;
        end
        check("backpressure_stable", bad, 0);
        @(posedge clk);
        #1 key_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("accept_clears_valid", key_valid, 0);
        check("accept_clears_onehot", key_onehot, 0);
        repeat (60) @(posedge clk);
        check("backpressure_one_event", transfers - base, 1);

        // Two keys on row 1: c0 and c2.
        base = transfers;
`ifdef KEYPAD_GHOST_REJECT_EN
        drive_keys(16'h0050);
        repeat (100) @(posedge clk);
        check("ghost_no_event", transfers - base, 0);
        @(negedge clk);
        check("ghost_valid_low", key_valid, 0);
        exp_q.push_back(16'h0040);
        drive_keys(16'h0040);
        wait_valid(WAIT_BUDGET, ok);
        if (ok) check("ghost_single_onehot", key_onehot, 16'h0040);
`else
        exp_q.push_back(16'h0010);
        drive_keys(16'h0050);
        wait_valid(WAIT_BUDGET, ok);
        if (ok) check("two_key_lowest_col", key_onehot, 16'h0010);
`endif
        drive_keys(16'h0000);
        repeat (40) @(posedge clk);
        check("two_key_one_event", transfers - base, 1);

        // Hold r0/c0 long after acceptance, release, press again.
        base = transfers;
        exp_q.push_back(16'h0001);
        drive_keys(16'h0001);
        wait_valid(WAIT_BUDGET, ok);
        if (ok) check("hold_first_onehot", key_onehot, 16'h0001);
        repeat (100) @(posedge clk);
        check("hold_no_repeat", transfers - base, 1);
        drive_keys(16'h0000);
        repeat (40) @(posedge clk);
        exp_q.push_back(16'h0001);
        drive_keys(16'h0001);
        wait_valid(WAIT_BUDGET, ok);
        if (ok) check("hold_second_onehot", key_onehot, 16'h0001);
        drive_keys(16'h0000);
        repeat (40) @(posedge clk);
        check("hold_two_events", transfers - base, 2);

        // key_ready with nothing held is ignored.
        key_ready = 1'b1;
        repeat (40) @(posedge clk);
        check("idle_ready_no_event", transfers - base, 2);

        check("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
